// File: rtl/comparator_sort_ctrl_pkg.sv
// Shared definitions for the comparator-based bubble-sort engine:
// controller state encoding and swap-count width.
package comparator_sort_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_COMPARE  = 3'd1,
        ST_SWAP     = 3'd2,
        ST_PASS_END = 3'd3,
        ST_DONE     = 3'd4
    } sort_state_t;

    localparam int SWAP_W = 8;
    localparam logic [SWAP_W-1:0] SWAP_MAX = '1;

endpackage

// File: rtl/comparator_sort_ctrl_cmp.sv
// Four-bit magnitude comparator; the single shared compare resource of the sorter.
module comparator_sort_ctrl_cmp (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       eq,
    output logic       gt,
    output logic       lt
);

    always_comb begin
        eq = (a == b);
        gt = (a > b);
        lt = (a < b);
    end

endmodule

// File: rtl/comparator_sort_ctrl.sv
// Sequential bubble sort over an N-entry file of 4-bit values, time-sharing one
// comparator. Host loads entries in IDLE, pulses start, waits for done.
module comparator_sort_ctrl
    import comparator_sort_ctrl_pkg::*;
#(
    parameter int  N      = 4,
    parameter bit  ASCEND = 1'b1,
    localparam int ADDR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [3:0]        wr_data,
    input  logic              start,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [3:0]        rd_data,
    output logic              busy,
    output logic              done,
    output logic [SWAP_W-1:0] swap_count
);

    localparam logic [ADDR_W:0]   N_L        = N[ADDR_W:0];
    localparam logic [ADDR_W-1:0] LIMIT_INIT = ADDR_W'(N - 1);
    localparam logic [ADDR_W-1:0] LIMIT_ONE  = ADDR_W'(1);

    sort_state_t       state, state_nxt;
    logic [3:0]        mem [N];
    logic [ADDR_W-1:0] idx, idx_nxt, limit;
    logic              pass_swapped;
    logic              cmp_eq, cmp_gt, cmp_lt;
    logic              out_of_order, last_pair, finish_sort, wr_ok;

    assign idx_nxt      = idx + 1'b1;
    assign last_pair    = (idx_nxt == limit);
    assign finish_sort  = !pass_swapped || (limit == LIMIT_ONE);
    assign wr_ok        = ({1'b0, wr_addr} < N_L);
    // Equal operands never swap, which keeps the sort stable.
    assign out_of_order = !cmp_eq && (ASCEND ? cmp_gt : cmp_lt);

    comparator_sort_ctrl_cmp u_fourbit_comparator (
        .a  (mem[idx]),
        .b  (mem[idx_nxt]),
        .eq (cmp_eq),
        .gt (cmp_gt),
        .lt (cmp_lt)
    );

    always_comb begin
        rd_data = '0;
        if ({1'b0, rd_addr} < N_L) begin
            rd_data = mem[rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:     if (start && !load) state_nxt = ST_COMPARE;
            ST_COMPARE: begin
                if (out_of_order)   state_nxt = ST_SWAP;
                else if (last_pair) state_nxt = ST_PASS_END;
            end
            ST_SWAP:     state_nxt = last_pair ? ST_PASS_END : ST_COMPARE;
            ST_PASS_END: state_nxt = finish_sort ? ST_DONE : ST_COMPARE;
            ST_DONE:     state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (state != ST_IDLE);
        done = (state == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                mem[i] <= '0;
            end
            idx          <= '0;
            limit        <= LIMIT_INIT;
            pass_swapped <= 1'b0;
            swap_count   <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    // A write takes priority; start is only accepted with load low.
                    if (load) begin
                        if (wr_ok) mem[wr_addr] <= wr_data;
                    end else if (start) begin
                        idx          <= '0;
                        limit        <= LIMIT_INIT;
                        pass_swapped <= 1'b0;
                        swap_count   <= '0;
                    end
                end
                ST_COMPARE: begin
                    if (!out_of_order && !last_pair) idx <= idx_nxt;
                end
                ST_SWAP: begin
                    mem[idx]     <= mem[idx_nxt];
                    mem[idx_nxt] <= mem[idx];
                    pass_swapped <= 1'b1;
                    if (swap_count != SWAP_MAX) swap_count <= swap_count + 1'b1;
                    if (!last_pair) idx <= idx_nxt;
                end
                ST_PASS_END: begin
                    if (!finish_sort) begin
                        limit        <= limit - 1'b1;
                        idx          <= '0;
                        pass_swapped <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_comparator_sort_ctrl.sv
// Directed bench for comparator_sort_ctrl: one ascending and one descending instance,
// hand-computed contents, swap counts and start-to-done cycle counts.
module tb_comparator_sort_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load = 1'b0, load_d = 1'b0;
    logic       start = 1'b0, start_d = 1'b0;
    logic [1:0] wr_addr = '0, rd_addr = '0;
    logic [3:0] wr_data = '0;
    logic [3:0] rd_data, rd_data_d;
    logic       busy, busy_d, done, done_d;
    logic [7:0] swap_count, swap_count_d;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc;

    always #5 clk = ~clk;

    comparator_sort_ctrl #(.N(4), .ASCEND(1'b1)) dut (
        .clk(clk), .rst(rst), .load(load), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy),
        .done(done), .swap_count(swap_count)
    );

    comparator_sort_ctrl #(.N(4), .ASCEND(1'b0)) dut_desc (
        .clk(clk), .rst(rst), .load(load_d), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start_d), .rd_addr(rd_addr), .rd_data(rd_data_d), .busy(busy_d),
        .done(done_d), .swap_count(swap_count_d)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic write_word(input logic [1:0] a, input logic [3:0] d, input logic both);
        @(negedge clk);
        wr_addr = a; wr_data = d; load = 1'b1; load_d = both;
        @(negedge clk);
        load = 1'b0; load_d = 1'b0;
    endtask

    task automatic write_vec(input logic [3:0] v0, v1, v2, v3, input logic both);
        write_word(2'd0, v0, both);
        write_word(2'd1, v1, both);
        write_word(2'd2, v2, both);
        write_word(2'd3, v3, both);
    endtask

    task automatic check_mem(input string tag, input logic [3:0] v0, v1, v2, v3,
                             input logic desc);
        logic [3:0] ev [4];
        ev[0] = v0; ev[1] = v1; ev[2] = v2; ev[3] = v3;
        for (int i = 0; i < 4; i++) begin
            rd_addr = 2'(i);
            #1;
            check($sformatf("%s[%0d]", tag, i), desc ? rd_data_d : rd_data, ev[i]);
        end
    endtask

    // Leaves the bench at the negedge inside the first busy cycle (count 1).
    task automatic pulse_start(input logic desc);
        @(negedge clk);
        if (desc) start_d = 1'b1; else start = 1'b1;
        @(negedge clk);
        start = 1'b0; start_d = 1'b0;
    endtask

    // Counts busy cycles up to and including the done cycle, bounded.
    task automatic wait_done(input int c0, output int c, input logic desc);
        c = c0;
        while (!(desc ? done_d : done) && c < 100) begin
            @(negedge clk);
            c++;
        end
    endtask

    task automatic check_after_done(input string tag);
        @(negedge clk);
        check({tag, "_done_single"}, done, 0);
        check({tag, "_busy_clear"}, busy, 0);
    endtask

    initial begin
        // 1: reset
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_swaps", swap_count, 0);
        check_mem("rst_mem", 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);

        // 2: [3,1,2,0] has 5 inversions; passes take 7+4+3 cycles plus DONE = 15
        write_vec(4'd3, 4'd1, 4'd2, 4'd0, 1'b0);
        pulse_start(1'b0);
        check("t2_busy", busy, 1);
        wait_done(1, cyc, 1'b0);
        check("t2_latency", cyc, 15);
        check("t2_swaps", swap_count, 5);
        check_after_done("t2");
        check_mem("t2_mem", 4'd0, 4'd1, 4'd2, 4'd3, 1'b0);

        // 3: already sorted
        write_vec(4'd0, 4'd1, 4'd2, 4'd3, 1'b0);
        pulse_start(1'b0);
        check("t3_swaps_cleared", swap_count, 0);
        wait_done(1, cyc, 1'b0);
        check("t3_latency", cyc, 5);
        check("t3_swaps", swap_count, 0);
        check_after_done("t3");
        check_mem("t3_mem", 4'd0, 4'd1, 4'd2, 4'd3, 1'b0);

        // 4: duplicates, both orders
        write_vec(4'd15, 4'd8, 4'd8, 4'd0, 1'b1);
        pulse_start(1'b1);
        wait_done(1, cyc, 1'b1);
        check("t4d_latency", cyc, 5);
        check("t4d_swaps", swap_count_d, 0);
        @(negedge clk);
        check_mem("t4d_mem", 4'd15, 4'd8, 4'd8, 4'd0, 1'b1);
        pulse_start(1'b0);
        wait_done(1, cyc, 1'b0);
        check("t4a_latency", cyc, 15);
        check("t4a_swaps", swap_count, 5);
        check_after_done("t4a");
        check_mem("t4a_mem", 4'd0, 4'd8, 4'd8, 4'd15, 1'b0);

        // 5: fully reversed, load and start pulsed while busy are ignored
        write_vec(4'd3, 4'd2, 4'd1, 4'd0, 1'b0);
        pulse_start(1'b0);
        @(negedge clk);
        wr_addr = 2'd0; wr_data = 4'd9; load = 1'b1; start = 1'b1;
        @(negedge clk);
        load = 1'b0; start = 1'b0;
        wait_done(3, cyc, 1'b0);
        check("t5_latency", cyc, 16);
        check("t5_swaps", swap_count, 6);
        check_after_done("t5");
        check_mem("t5_mem", 4'd0, 4'd1, 4'd2, 4'd3, 1'b0);

        // 6: reset mid-sort, then load+start together in IDLE
        write_vec(4'd3, 4'd2, 4'd1, 4'd0, 1'b0);
        pulse_start(1'b0);
        repeat (3) begin
            @(negedge clk);
            check("t6_no_done", done, 0);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t6_busy", busy, 0);
        check("t6_done", done, 0);
        check("t6_swaps", swap_count, 0);
        check_mem("t6_mem", 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
        @(negedge clk);
        wr_addr = 2'd2; wr_data = 4'd7; load = 1'b1; start = 1'b1;
        @(negedge clk);
        load = 1'b0; start = 1'b0;
        check("t6_ls_busy", busy, 0);
        @(negedge clk);
        check("t6_ls_busy2", busy, 0);
        check_mem("t6_ls_mem", 4'd0, 4'd0, 4'd7, 4'd0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
